// File: rtl/axis_parity_splitter_if.sv
// Stream bundle for axis_parity_splitter: one input stream, odd and even output streams.
// Ports: axis_s_* input stream (tvalid/tready/tdata/tlast); axis_m_*_odd / axis_m_*_even
//        output streams with the same four signals each. slave = splitter side, master = peer side.
interface axis_parity_splitter_if #(
  parameter int DATA_W = 8
);
  logic              axis_s_tvalid;
  logic              axis_s_tready;
  logic [DATA_W-1:0] axis_s_tdata;
  logic              axis_s_tlast;

  logic              axis_m_tvalid_odd;
  logic              axis_m_tready_odd;
  logic [DATA_W-1:0] axis_m_tdata_odd;
  logic              axis_m_tlast_odd;

  logic              axis_m_tvalid_even;
  logic              axis_m_tready_even;
  logic [DATA_W-1:0] axis_m_tdata_even;
  logic              axis_m_tlast_even;

  modport slave (
    input  axis_s_tvalid, axis_s_tdata, axis_s_tlast,
    output axis_s_tready,
    output axis_m_tvalid_odd, axis_m_tdata_odd, axis_m_tlast_odd,
    input  axis_m_tready_odd,
    output axis_m_tvalid_even, axis_m_tdata_even, axis_m_tlast_even,
    input  axis_m_tready_even
  );

  modport master (
    output axis_s_tvalid, axis_s_tdata, axis_s_tlast,
    input  axis_s_tready,
    input  axis_m_tvalid_odd, axis_m_tdata_odd, axis_m_tlast_odd,
    output axis_m_tready_odd,
    input  axis_m_tvalid_even, axis_m_tdata_even, axis_m_tlast_even,
    output axis_m_tready_even
  );
endinterface

// File: rtl/axis_parity_splitter.sv
// Splits an AXI-Stream by beat parity into odd/even streams, each behind a FWFT FIFO.
// Latency: a beat leaves one cycle after the next same-class beat, or 2 edges after tlast.
// Backpressure: s_tready drops in FLUSH or when either FIFO is full (head-of-line coupled).
// Ports: a_clk, axis_aresetn (async, active-low), axis (slave modport of the stream bundle).
module axis_parity_splitter #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int MODE       = 0
) (
  input  logic                   a_clk,
  input  logic                   axis_aresetn,
  axis_parity_splitter_if.slave  axis
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  // Class index: 1 = odd, 0 = even.
  state_t            state, state_nxt;
  logic              live;
  logic [1:0]        hold_v, hold_v_nxt;
  logic [1:0]        need, need_nxt;
  logic [DATA_W-1:0] hold_d [2];
  logic [DATA_W:0]   mem [2][FIFO_DEPTH];   // {last, data}
  logic [AW:0]       wr_ptr [2];
  logic [AW:0]       rd_ptr [2];
  logic [1:0]        full, empty, push, pop;
  logic              cls, s_hs;

  assign cls = (MODE == 1) ? axis.axis_s_tdata[0] : ^axis.axis_s_tdata;

  // live keeps tready low until the first edge after reset release.
  assign axis.axis_s_tready = live && (state == RUN) && !full[0] && !full[1];
  assign s_hs = axis.axis_s_tvalid && axis.axis_s_tready;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      full[c]  = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                 (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
    end
  end

  assign pop[1] = !empty[1] && axis.axis_m_tready_odd;
  assign pop[0] = !empty[0] && axis.axis_m_tready_even;

  always_comb begin
    state_nxt  = state;
    hold_v_nxt = hold_v;
    need_nxt   = need;
    push       = '0;
    case (state)
      RUN: begin
        if (s_hs) begin
          // The previous beat of this class is now known not to be its last.
          push[cls]       = hold_v[cls];
          hold_v_nxt[cls] = 1'b1;
          if (axis.axis_s_tlast) begin
            state_nxt = FLUSH;
            need_nxt  = hold_v_nxt;
          end
        end
      end
      FLUSH: begin
        for (int c = 0; c < 2; c++) begin
          if (need[c] && !full[c]) begin
            push[c]       = 1'b1;
            hold_v_nxt[c] = 1'b0;
            need_nxt[c]   = 1'b0;
          end
        end
        if (need_nxt == 2'b00) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge a_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state  <= RUN;
      live   <= 1'b0;
      hold_v <= '0;
      need   <= '0;
      for (int c = 0; c < 2; c++) begin
        hold_d[c] <= '0;
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem[c][i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      live   <= 1'b1;
      hold_v <= hold_v_nxt;
      need   <= need_nxt;
      if (s_hs) hold_d[cls] <= axis.axis_s_tdata;
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          // Pushes from FLUSH close the class for this packet.
          mem[c][wr_ptr[c][AW-1:0]] <= {state == FLUSH, hold_d[c]};
          wr_ptr[c] <= wr_ptr[c] + (AW+1)'(1);
        end
        if (pop[c]) rd_ptr[c] <= rd_ptr[c] + (AW+1)'(1);
      end
    end
  end

  assign axis.axis_m_tvalid_odd  = !empty[1];
  assign axis.axis_m_tdata_odd   = mem[1][rd_ptr[1][AW-1:0]][DATA_W-1:0];
  assign axis.axis_m_tlast_odd   = mem[1][rd_ptr[1][AW-1:0]][DATA_W];
  assign axis.axis_m_tvalid_even = !empty[0];
  assign axis.axis_m_tdata_even  = mem[0][rd_ptr[0][AW-1:0]][DATA_W-1:0];
  assign axis.axis_m_tlast_even  = mem[0][rd_ptr[0][AW-1:0]][DATA_W];
endmodule

// File: doc/axis_parity_splitter.md
# axis_parity_splitter

Parametrised AXI-Stream demultiplexer that classifies each input beat as odd or even and routes it to one of two output streams, buffering each output in its own FIFO. Packet boundaries are preserved per output: each output carries `tlast` on the last beat of its own class within an input packet. It is the successor to the fixed 8-byte parity filter and adds several things that block lacks: full per-output backpressure, configurable width and depth, a classification mode, and streaming of packets of unbounded length.

## Interface
- `DATA_W`, default 8: beat width in bits, ≥1.
- `FIFO_DEPTH`, default 8: entries per output FIFO; must be a power of two, ≥2.
- `MODE`, default 0: classification rule. 0 = XOR parity of all `DATA_W` bits, where 1 means odd. 1 = numeric parity (`tdata[0]`), where 1 means odd.

- `a_clk`  in  1  sole clock, rising edge.
- `axis_aresetn`  in  1  reset, asynchronous and active-low.
- `axis_s_tvalid`  in  1  input beat valid.
- `axis_s_tready`  out  1  input ready.
- `axis_s_tdata`  in  DATA_W  input beat.
- `axis_s_tlast`  in  1  last beat of input packet.
- `axis_m_tvalid_odd` / `axis_m_tready_odd` / `axis_m_tdata_odd` / `axis_m_tlast_odd`  out/in/out/out  1/1/DATA_W/1  odd output stream.
- `axis_m_tvalid_even` / `axis_m_tready_even` / `axis_m_tdata_even` / `axis_m_tlast_even`  out/in/out/out  1/1/DATA_W/1  even output stream.

## Operation
- **Transfers:** a transfer occurs on any interface when tvalid && tready are both high at a rising edge.
- **Hold registers:** there is one per class (`hold_v`, `hold_d`). A beat is not known to be the last of its class until a later beat arrives or the packet ends, so each class keeps its most recent beat in its hold register.
- **FSM states:** RUN and FLUSH.
- **RUN, non-last beat accepted, class c:**
  - If `hold_v[c]`, push `{hold_d[c], last=0}` into FIFO c.
  - Then `hold[c] <= beat`.
- **RUN, beat with `tlast` accepted, class c:**
  - Same as a non-last beat.
  - Go to FLUSH and set `need_odd = hold_v_odd'` and `need_even = hold_v_even'`, both evaluated after the update.
- **FLUSH:**
  - For each class with `need` set and its FIFO not full: push `{hold_d, last=1}`, then clear `hold_v` and `need`.
  - The two classes flush independently, so zero, one or two pushes may occur in a cycle.
  - Return to RUN in the cycle after both `need` flags are clear.
- **Empty class:** a class that received no beats in a packet emits nothing for that packet. No empty marker is produced.
- **Input ready:** `axis_s_tready` = (state==RUN) && !full_odd && !full_even. It is registered-free combinational logic from state and FIFO flags, and it never depends on `axis_s_tvalid`.
- **FIFOs:** first-word fall-through. `m_tvalid` = !empty; `m_tdata` and `m_tlast` come from the head entry.
- **Simultaneous push and pop** on one FIFO in the same cycle is always legal when the FIFO is not empty; the count is unchanged.
- **Pointers:** log2(FIFO_DEPTH)+1 bits, wrapping naturally. Full when the MSBs differ and the rest are equal.
- **Reset:** asserting `axis_aresetn` low at any time, including mid-packet, discards the hold registers and the FIFO contents.

## Timing
- **Reset values:**
  - All `m_tvalid` = 0.
  - `axis_s_tready` = 0 while reset is asserted.
  - State = RUN, `hold_v` = 0, pointers = 0.
  - `m_tdata` and `m_tlast` read as the head of an empty FIFO; they are don't-care while tvalid=0, but the memory is reset to 0.
- **After reset deassertion:** `axis_s_tready` = 1 from the first clock edge.
- **Non-last beat latency:** appears on its output in the cycle after the next same-class beat is accepted.
- **Last-of-class beat latency:** appears in the cycle after the FLUSH edge, i.e. 2 edges after the `tlast` beat is accepted, provided its FIFO is not full.
- **Packet bubble:** at least one cycle with `axis_s_tready`=0 after every `tlast` beat. Sustained throughput is 1 beat/cycle within a packet.
- **Stalled output:** a stall on either output eventually deasserts `axis_s_tready`. This head-of-line coupling is intended.
- **FLUSH with a full FIFO:** FLUSH persists until that FIFO has space. No deadlock occurs provided the consumer eventually asserts its tready.

## Test plan
- **Mixed packet:** MODE=0, packet 0x01, 0x03, 0x07, 0xFF(last), both outputs ready.
  - Odd output: 0x01, then 0x07 with tlast=1.
  - Even output: 0x03, then 0xFF with tlast=1.
  - `axis_s_tready`=0 for exactly 1 cycle after 0xFF.
- **Single-class packet:** packet 0x03, 0x05(last).
  - Even output: 0x03, then 0x05 with tlast=1.
  - Odd `m_tvalid` never asserts.
- **Classification mode:** MODE=1, packet 0x03, 0x06(last).
  - Odd output: 0x03 with tlast=1.
  - Even output: 0x06 with tlast=1.
  - With MODE=0 the same packet yields even output only: 0x03, then 0x06 with tlast=1.
- **Backpressure:** FIFO_DEPTH=4, `axis_m_tready_odd`=0, feed 8 odd beats 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80(last).
  - `axis_s_tready` drops after 5 beats are accepted (4 in the FIFO, 1 in hold).
  - Releasing tready drains all 8 in order; only 0x80 carries tlast; no loss or duplication.
- **Random long stream:** 1000 random beats with random packet lengths 1–20 and random ready patterns on both outputs. A scoreboard checks:
  - per-class order;
  - one tlast per non-empty class per packet;
  - no tvalid drop without a handshake.
- **Reset mid-packet:** assert `axis_aresetn`=0 for 1 cycle after the 3rd beat of a 6-beat packet.
  - Both `m_tvalid` go to 0 immediately, asynchronously.
  - The next packet 0x01(last) emerges alone on the odd output with tlast=1.
